instruction_fetch_unit: RTL

//  IF stage: master side of the InstructionMemory port. Owns the PC, drives the word address and consumes the 1-cycle registered read data.

---
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch stage, the instruction memory port and decode.
// The master modport is the fetch unit; the slave modport is everything around it.
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirectPc;
    logic [DATA_WIDTH-1:0] imemData;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] instrOut;
    logic [ADDR_WIDTH-1:0] pcOut;
    logic                  validOut;
    logic                  halted;

    modport master (
        input  stall, redirect, redirectPc, imemData,
        output address, instrOut, pcOut, validOut, halted
    );

    modport slave (
        output stall, redirect, redirectPc, imemData,
        input  address, instrOut, pcOut, validOut, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the memory address from next-PC so the memory's
// output register doubles as the IF/ID register. Optional macro: IF_NOP_FILTER_EN.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [ADDR_WIDTH-1:0] LAST_PC    = '1
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  run_q;
    logic                  halted_q;
    logic                  valid;

    // Next-PC is needed combinationally because it is the memory address.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (reset) begin
            state_next = FILL;
            pc_next    = RESET_PC;
        end else begin
            case (state)
                FILL: state_next = RUN;
                RUN: begin
                    if (bus.redirect) begin
                        pc_next = bus.redirectPc;
                    end else if (bus.stall) begin
                        pc_next = pc;
                    end else if (pc == LAST_PC) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc + 1'b1;
                    end
                end
                HALT: begin
                    if (bus.redirect) begin
                        state_next = RUN;
                        pc_next    = bus.redirectPc;
                    end
                end
                default: begin
                    state_next = FILL;
                    pc_next    = RESET_PC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state    <= state_next;
        pc       <= pc_next;
        run_q    <= (state_next == RUN);
        halted_q <= (state_next == HALT);
    end

`ifdef IF_NOP_FILTER_EN
    // All-zero words are compiler bubbles and are not issued.
    assign valid = run_q && (bus.imemData != '0);
`else
    assign valid = run_q;
`endif

    assign bus.address  = pc_next;
    assign bus.pcOut    = pc;
    assign bus.validOut = valid;
    assign bus.halted   = halted_q;
    assign bus.instrOut = valid ? bus.imemData : '0;

endmodule
